// File: rtl/mult_pkg.sv
// Shared definitions for the Karatsuba multiplier library: accumulator sizing and
// the state encoding of the dot-product accumulation stage.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_t;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational accumulator adder with carry-out. With ACC_SAT_EN defined the sum
// clamps to all-ones on carry; an all-ones accumulator therefore stays pinned.
module acc_sat_add #(
  parameter int ACC_W = 24,
  parameter int IN_W  = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_add,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, i_add};
  assign o_carry = w_full[ACC_W];

`ifdef ACC_SAT_EN
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/karatsuba_dot_acc.sv
// Burst accumulator behind the Karatsuba multiplier: sums in_last-delimited product
// bursts and holds the total for a valid/ready consumer. Optional macro: ACC_SAT_EN.
module karatsuba_dot_acc
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int GUARD = 8,
  parameter  int CNT_W = 16,
  localparam int ACC_W = acc_w(WIDTH, GUARD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] product_in,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic [CNT_W-1:0]   term_count,
  output logic               overflow
);

  acc_state_t       r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic             w_accept;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  acc_sat_add #(.ACC_W(ACC_W), .IN_W(2 * WIDTH)) u_add (
    .i_acc   (r_acc),
    .i_add   (product_in),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign in_ready   = (r_state != ST_HOLD);
  assign out_valid  = (r_state == ST_HOLD);
  assign w_accept   = in_valid & in_ready;
  assign acc_out    = r_acc;
  assign term_count = r_cnt;
  assign overflow   = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = {{GUARD{1'b0}}, product_in};
          w_cnt_nxt   = CNT_W'(1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_sum;
          w_ovf_nxt   = r_ovf | w_carry;
          // term counter saturates rather than wrapping on very long bursts
          w_cnt_nxt   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
          w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_karatsuba_dot_acc.sv
// Self-checking bench for karatsuba_dot_acc: directed vector table, corner-case
// sequences and random bursts against a plain-arithmetic burst-sum model.
module tb_karatsuba_dot_acc;

  localparam int  WIDTH = 8;
  localparam int  GUARD = 8;
  localparam int  CNT_W = 16;
  localparam int  ACC_W = 24;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       product_in;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  term_count;
  logic              overflow;

  int n_chk  = 0;
  int n_pass = 0;

  karatsuba_dot_acc #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .product_in (product_in),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .term_count (term_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][15:0] p;
    int              gap;
    longint          eacc;
    longint          ecnt;
    longint          eovf;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Present one beat (after gap idle cycles) and hold it until accepted.
  task automatic beat(input logic [15:0] p, input logic last, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; product_in = p; in_last = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("beat_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for a result, check it, hold out_ready low for delay cycles, then consume.
  task automatic take(input string nm, input longint eacc, input longint ecnt,
                      input longint eovf, input int delay, output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    lat = t;
    if (!out_valid) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_acc"}, acc_out, eacc);
    chk({nm, "_cnt"}, term_count, ecnt);
    chk({nm, "_ovf"}, overflow, eovf);
    chk({nm, "_in_ready_hold"}, in_ready, 0);
    repeat (delay) begin
      @(negedge clk);
      chk({nm, "_stable_acc"}, acc_out, eacc);
      chk({nm, "_stable_vld"}, out_valid, 1);
      chk({nm, "_stable_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_idle_rdy"}, in_ready, 1);
    chk({nm, "_idle_vld"}, out_valid, 0);
  endtask

  // Reference model: whole-burst sum in wide arithmetic.
  function automatic longint model_acc(input longint total);
`ifdef ACC_SAT_EN
    return (total >= ACC_MOD) ? ACC_MOD - 1 : total;
`else
    return total % ACC_MOD;
`endif
  endfunction

  initial begin
    int     lat;
    longint total;
    int     n;
    logic [15:0] p;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; product_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_acc", acc_out, 0);
    chk("rst_cnt", term_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);

    vecs[0] = '{n: 2, p: {16'h0, 16'h0, 16'h0023, 16'h000C}, gap: 0,
                eacc: 64'h2F, ecnt: 2, eovf: 0};
    vecs[1] = '{n: 1, p: {16'h0, 16'h0, 16'h0, 16'hFE01}, gap: 0,
                eacc: 64'hFE01, ecnt: 1, eovf: 0};
    vecs[2] = '{n: 3, p: {16'h0, 16'h0003, 16'h0002, 16'h0001}, gap: 2,
                eacc: 64'h6, ecnt: 3, eovf: 0};
    vecs[3] = '{n: 4, p: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, gap: 1,
                eacc: 64'h3FFFC, ecnt: 4, eovf: 0};

    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        beat(vecs[v].p[b], b == vecs[v].n - 1, (b == 0) ? 0 : vecs[v].gap);
      take($sformatf("vec%0d", v), vecs[v].eacc, vecs[v].ecnt, vecs[v].eovf, 0, lat);
      chk($sformatf("vec%0d_latency", v), lat, 0);
    end

    // 257 beats of 0xFFFF, held back-to-back
    for (int b = 0; b < 257; b++) beat(16'hFFFF, b == 256, 0);
`ifdef ACC_SAT_EN
    take("long257", 64'hFFFFFF, 257, 1, 0, lat);
`else
    take("long257", 64'h00FEFF, 257, 1, 0, lat);
`endif

    // Backpressure: a waiting beat must not be absorbed while the result is held
    beat(16'h0010, 1'b0, 0);
    beat(16'h0020, 1'b0, 0);
    beat(16'h0030, 1'b1, 0);
    in_valid = 1'b1; product_in = 16'h0005; in_last = 1'b1;
    take("bp", 64'h60, 3, 0, 3, lat);
    beat(16'h0005, 1'b1, 0);
    take("bp_next", 64'h5, 1, 0, 0, lat);

    // Reset mid-burst discards the partial sum
    beat(16'h0100, 1'b0, 0);
    beat(16'h0200, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_acc", acc_out, 0);
    chk("midrst_cnt", term_count, 0);
    chk("midrst_vld", out_valid, 0);
    chk("midrst_rdy", in_ready, 1);
    beat(16'h0001, 1'b0, 0);
    beat(16'h0002, 1'b1, 0);
    take("post_rst", 64'h3, 2, 0, 0, lat);

    // Reset while holding a result
    beat(16'h0042, 1'b1, 0);
    @(negedge clk);
    chk("hold_before_rst", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("holdrst_vld", out_valid, 0);
    chk("holdrst_acc", acc_out, 0);

    // Random bursts vs. whole-burst arithmetic model
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 6);
      total = 0;
      for (int b = 0; b < n; b++) begin
        p = (r % 4 == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
        total += longint'(p);
        beat(p, b == n - 1, $urandom_range(0, 2));
      end
      take($sformatf("rand%0d", r), model_acc(total), n, 0, $urandom_range(0, 3), lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/karatsuba_dot_acc.md
Name: karatsuba_dot_acc

Overview:
- Sequential accumulation stage directly downstream of the team's combinational Karatsuba multiplier.
- Consumes a stream of 2*WIDTH-bit products over a valid/ready handshake and sums each burst, delimited by in_last, into a guarded accumulator.
- Presents the burst total, term count and overflow flag on an output valid/ready handshake.
- Forms the dot-product / MAC path of the multiplier library.

Parameters:
- WIDTH, 8, multiplier operand width; product input is 2*WIDTH bits.
- GUARD, 8, extra accumulator MSBs; ACC_W = 2*WIDTH+GUARD.
- CNT_W, 16, width of the term counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- product_in  input  2*WIDTH  unsigned product from multiplier
- in_last  input  1  beat is final term of burst
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- acc_out  output  ACC_W  burst sum
- term_count  output  CNT_W  number of terms summed in burst
- overflow  output  1  sum exceeded ACC_W bits during burst (sticky per burst)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, acc_out=0, term_count=0, overflow=0, out_valid=0. in_ready=1 from the first cycle after reset.
- Accept event: in_valid & in_ready.
- States:
  - IDLE: no burst in progress; in_ready=1.
  - ACCUM: burst in progress; in_ready=1.
  - HOLD: result presented; in_ready=0, out_valid=1.
- IDLE, on accept:
  - acc <= zero-extended product_in; count <= 1; ovf <= 0.
  - Next state is HOLD if in_last, else ACCUM.
- ACCUM, on accept:
  - acc <= acc + product_in, modulo 2^ACC_W.
  - ovf <= ovf | carry-out.
  - count <= count+1, saturating at 2^CNT_W-1.
  - Next state is HOLD if in_last, else ACCUM.
- ACCUM without accept: all registers hold.
- HOLD:
  - acc_out, term_count and overflow are stable while out_valid & ~out_ready.
  - On out_ready: out_valid <= 0, state <= IDLE. The next beat can be accepted the following cycle.
- Latency: out_valid rises on the cycle after the last beat is accepted. Minimum burst cadence is N+1 cycles for N terms.
- Single-term burst (in_last on first beat): acc_out = product_in, term_count = 1.
- in_last with in_valid low is ignored.
- Beats presented while in HOLD are not accepted (in_ready=0); the upstream stage must hold them.
- rst mid-burst or in HOLD: the partial or unconsumed result is discarded and all outputs return to reset values on the next edge.
- Arithmetic is unsigned throughout; product_in is zero-extended to ACC_W.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: on carry-out, acc saturates to all-ones (2^ACC_W-1) and stays there for the rest of the burst. overflow is still set.
- Undefined: acc wraps modulo 2^ACC_W; overflow flags the wrap.
- The handshake and counting are identical in both builds.

Decomposition:
- Shared package mult_pkg:
  - ACC_W derivation function.
  - State encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2.
- One natural sub-module, acc_sat_add:
  - Combinational ACC_W adder with carry-out.
  - Contains the ACC_SAT_EN saturation mux.
- Top-level karatsuba_dot_acc holds the FSM, registers and counter.

Test Plan (all with WIDTH=8, GUARD=8, CNT_W=16):
- Burst 0x000C, 0x0023 (last), out_ready=1 -> one cycle after the last beat: out_valid=1, acc_out=0x00002F, term_count=2, overflow=0.
- Single beat 0xFE01 with in_last -> acc_out=0x00FE01, term_count=1; returns to IDLE after the handshake.
- 257 beats of 0xFFFF, last on beat 257:
  - Without ACC_SAT_EN -> acc_out=0x00FEFF, overflow=1, term_count=257.
  - With ACC_SAT_EN -> acc_out=0xFFFFFF, overflow=1.
- Backpressure: burst of 3 beats, out_ready low for 3 cycles -> outputs stable and in_ready=0 throughout; new burst accepted only after out_ready pulses.
- in_valid toggling mid-burst (gaps of 2 cycles) -> sum is unaffected by the gaps.
- rst asserted after 2 of 4 beats -> outputs zero, state IDLE; a following fresh 2-beat burst 0x0001, 0x0002 -> acc_out=0x000003, term_count=2.
